// File: rtl/fir_coeff_ctrl_if.sv
// Coefficient load/commit bus between a config master and fir_coeff_ctrl.
// With FIR_COEFF_CHK_EN defined it also carries the cfg_chk checksum word.
interface fir_coeff_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int TAPS  = 4
);
   logic                        cfg_valid;
   logic                        cfg_ready;
   logic [WIDTH-1:0]            cfg_data;
   logic                        cfg_last;
   logic                        commit;
   logic                        sample_strobe;
   logic [TAPS-1:0][WIDTH-1:0]  coeffs;
   logic                        loaded;
   logic                        swap_done;
   logic                        cfg_err;
`ifdef FIR_COEFF_CHK_EN
   logic [WIDTH-1:0]            cfg_chk;

   modport master (
      output cfg_valid, cfg_data, cfg_last, commit, sample_strobe, cfg_chk,
      input  cfg_ready, coeffs, loaded, swap_done, cfg_err
   );
   modport slave (
      input  cfg_valid, cfg_data, cfg_last, commit, sample_strobe, cfg_chk,
      output cfg_ready, coeffs, loaded, swap_done, cfg_err
   );
`else
   modport master (
      output cfg_valid, cfg_data, cfg_last, commit, sample_strobe,
      input  cfg_ready, coeffs, loaded, swap_done, cfg_err
   );
   modport slave (
      input  cfg_valid, cfg_data, cfg_last, commit, sample_strobe,
      output cfg_ready, coeffs, loaded, swap_done, cfg_err
   );
`endif
endinterface

// File: rtl/fir_coeff_ctrl.sv
// Shadow/active coefficient bank controller: serial load, commit, swap on the next sample strobe.
// Stalls cfg words (cfg_ready=0) while armed or pending; FIR_COEFF_CHK_EN adds an XOR checksum on the load.
module fir_coeff_ctrl #(
   parameter int WIDTH = 16,
   parameter int TAPS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   fir_coeff_ctrl_if.slave   bus
);
   localparam int IW = $clog2(TAPS);
   localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, ARMED, PENDING} state_t;

   state_t                     state_q, state_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [TAPS-1:0][WIDTH-1:0] shadow_q, shadow_d;
   logic [TAPS-1:0][WIDTH-1:0] coeffs_q, coeffs_d;
   logic                       ready_q, ready_d;
   logic                       loaded_q, loaded_d;
   logic                       swap_q, swap_d;
   logic                       err_q, err_d;
   logic                       xfer;
   logic                       chk_ok;
`ifdef FIR_COEFF_CHK_EN
   logic [WIDTH-1:0]           xor_q, xor_d;
`endif

   assign xfer = bus.cfg_valid && ready_q;

`ifdef FIR_COEFF_CHK_EN
   // The final word is folded in here so the compare sees the whole load.
   assign chk_ok = ((xor_q ^ bus.cfg_data) == bus.cfg_chk);
`else
   assign chk_ok = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      coeffs_d = coeffs_q;
      ready_d  = ready_q;
      loaded_d = loaded_q;
      swap_d   = 1'b0;
      err_d    = err_q;
`ifdef FIR_COEFF_CHK_EN
      xor_d    = xor_q;
`endif
      case (state_q)
         IDLE: begin
            if (xfer) begin
               shadow_d[0] = bus.cfg_data;
`ifdef FIR_COEFF_CHK_EN
               xor_d = bus.cfg_data;
`endif
               if (bus.cfg_last) begin
                  err_d = 1'b1;
                  idx_d = '0;
               end else begin
                  err_d   = 1'b0;
                  idx_d   = IW'(1);
                  state_d = LOAD;
               end
            end
         end
         LOAD: begin
            if (xfer) begin
               shadow_d[idx_q] = bus.cfg_data;
`ifdef FIR_COEFF_CHK_EN
               xor_d = xor_q ^ bus.cfg_data;
`endif
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  if (bus.cfg_last && chk_ok) begin
                     state_d  = ARMED;
                     loaded_d = 1'b1;
                     ready_d  = 1'b0;
                  end else begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
               end else if (bus.cfg_last) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ARMED: begin
            if (bus.commit) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            // All taps move together so the FIR never sees a mixed bank.
            if (bus.sample_strobe) begin
               coeffs_d = shadow_q;
               swap_d   = 1'b1;
               loaded_d = 1'b0;
               ready_d  = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         shadow_q <= '0;
         coeffs_q <= '0;
         ready_q  <= 1'b1;
         loaded_q <= 1'b0;
         swap_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef FIR_COEFF_CHK_EN
         xor_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         coeffs_q <= coeffs_d;
         ready_q  <= ready_d;
         loaded_q <= loaded_d;
         swap_q   <= swap_d;
         err_q    <= err_d;
`ifdef FIR_COEFF_CHK_EN
         xor_q    <= xor_d;
`endif
      end
   end

   assign bus.cfg_ready = ready_q;
   assign bus.coeffs    = coeffs_q;
   assign bus.loaded    = loaded_q;
   assign bus.swap_done = swap_q;
   assign bus.cfg_err   = err_q;
endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Randomized + directed bench for fir_coeff_ctrl against a word-list reference model.
module tb_fir_coeff_ctrl;
   localparam int WIDTH = 16;
   localparam int TAPS  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fir_coeff_ctrl_if #(.WIDTH(WIDTH), .TAPS(TAPS)) bus ();
   fir_coeff_ctrl #(.WIDTH(WIDTH), .TAPS(TAPS)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_fail   = 0;
   bit checking = 1'b0;
   int swaps_seen = 0;

   // Reference model: the words of the load in progress plus a few phase flags.
   logic [WIDTH-1:0] words[$];
   logic [WIDTH-1:0] m_shadow[TAPS];
   logic [WIDTH-1:0] m_active[TAPS];
   bit m_armed   = 1'b0;
   bit m_pending = 1'b0;
   bit m_err     = 1'b0;
   bit m_swap    = 1'b0;

`ifdef FIR_COEFF_CHK_EN
   bit chk_bad = 1'b0;

   function automatic logic [WIDTH-1:0] words_xor();
      logic [WIDTH-1:0] x = '0;
      foreach (words[i]) x ^= words[i];
      return x;
   endfunction
`endif

   function automatic logic [TAPS*WIDTH-1:0] exp_coeffs();
      logic [TAPS*WIDTH-1:0] p = '0;
      for (int i = 0; i < TAPS; i++) p[i*WIDTH +: WIDTH] = m_active[i];
      return p;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   always @(posedge clk) begin
      bit ok;
      int n;
      m_swap = 1'b0;
      if (rst) begin
         words.delete();
         m_armed = 0; m_pending = 0; m_err = 0;
         for (int i = 0; i < TAPS; i++) begin m_active[i] = '0; m_shadow[i] = '0; end
      end else if (m_pending) begin
         if (bus.sample_strobe) begin
            for (int i = 0; i < TAPS; i++) m_active[i] = m_shadow[i];
            m_swap = 1'b1;
            m_pending = 1'b0;
         end
      end else if (m_armed) begin
         if (bus.commit) begin m_armed = 1'b0; m_pending = 1'b1; end
      end else if (bus.cfg_valid) begin
         words.push_back(bus.cfg_data);
         n = words.size();
         if (n == 1) m_err = 1'b0;
         if (bus.cfg_last) begin
            ok = (n == TAPS);
`ifdef FIR_COEFF_CHK_EN
            ok = ok && (words_xor() == bus.cfg_chk);
`endif
            if (ok) begin
               for (int i = 0; i < TAPS; i++) m_shadow[i] = words[i];
               m_armed = 1'b1;
            end else begin
               m_err = 1'b1;
            end
            words.delete();
         end else if (n == TAPS) begin
            m_err = 1'b1;
            words.delete();
         end
      end
   end

   always @(negedge clk) begin
      if (bus.swap_done === 1'b1) swaps_seen++;
      if (checking) begin
         check("coeffs",    64'(bus.coeffs),  64'(exp_coeffs()));
         check("cfg_ready", 64'(bus.cfg_ready), 64'(!(m_armed || m_pending)));
         check("loaded",    64'(bus.loaded),    64'(m_armed || m_pending));
         check("swap_done", 64'(bus.swap_done), 64'(m_swap));
         check("cfg_err",   64'(bus.cfg_err),   64'(m_err));
      end
   end

   task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic l,
                      input logic cm, input logic st);
      bus.cfg_valid     = v;
      bus.cfg_data      = d;
      bus.cfg_last      = l;
      bus.commit        = cm;
      bus.sample_strobe = st;
`ifdef FIR_COEFF_CHK_EN
      bus.cfg_chk = words_xor() ^ d ^ (chk_bad ? WIDTH'(1) : WIDTH'(0));
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, '0, 0, 0, 0);
   endtask

   task automatic load4(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                        input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3);
      cyc(1, w0, 0, 0, 0);
      cyc(1, w1, 0, 0, 0);
      cyc(1, w2, 0, 0, 0);
      cyc(1, w3, 1, 0, 0);
   endtask

   initial begin
      int sw0;
      cyc(0, '0, 0, 0, 0);
      checking = 1'b1;
      cyc(0, '0, 0, 0, 0);
      rst = 1'b0;
      idle(10);
      check("reset_coeffs", 64'(bus.coeffs), 64'h0);
      check("reset_ready",  64'(bus.cfg_ready), 64'h1);
      check("reset_loaded", 64'(bus.loaded), 64'h0);
      check("reset_err",    64'(bus.cfg_err), 64'h0);

      // Basic load, commit, strobe three cycles later.
      load4(16'd128, 16'd64, 16'hFFC0, 16'd32);
      check("armed_loaded", 64'(bus.loaded), 64'h1);
      check("armed_ready",  64'(bus.cfg_ready), 64'h0);
      cyc(0, '0, 0, 1, 0);
      idle(2);
      check("pre_strobe_coeffs", 64'(bus.coeffs), 64'h0);
      sw0 = swaps_seen;
      cyc(0, '0, 0, 0, 1);
      check("swap_coeffs", 64'(bus.coeffs), 64'h0020_FFC0_0040_0080);
      check("model_coeffs", 64'(exp_coeffs()), 64'h0020_FFC0_0040_0080);
      check("swap_pulse", 64'(bus.swap_done), 64'h1);
      check("swap_loaded", 64'(bus.loaded), 64'h0);
      idle(3);
      check("swap_once", 64'(swaps_seen - sw0), 64'h1);

      // Early cfg_last on word 2, then a good load recovers.
      cyc(1, 16'd7, 0, 0, 0);
      cyc(1, 16'd9, 1, 0, 0);
      check("early_last_err", 64'(bus.cfg_err), 64'h1);
      check("early_last_coeffs", 64'(bus.coeffs), 64'h0020_FFC0_0040_0080);
      check("early_last_ready", 64'(bus.cfg_ready), 64'h1);
      cyc(1, 16'h0001, 0, 0, 0);
      check("err_cleared", 64'(bus.cfg_err), 64'h0);
      cyc(1, 16'hFFFF, 0, 0, 0);
      cyc(1, 16'h7FFF, 0, 0, 0);
      cyc(1, 16'h8000, 1, 0, 0);
      cyc(0, '0, 0, 1, 0);
      cyc(0, '0, 0, 0, 1);
      check("recover_coeffs", 64'(bus.coeffs), 64'h8000_7FFF_FFFF_0001);

      // Commit and strobe together: swap waits for the following strobe.
      load4(16'd5, 16'd6, 16'd7, 16'd8);
      cyc(0, '0, 0, 1, 1);
      check("same_cycle_no_swap", 64'(bus.coeffs), 64'h8000_7FFF_FFFF_0001);
      check("same_cycle_loaded", 64'(bus.loaded), 64'h1);
      idle(2);
      cyc(0, '0, 0, 0, 1);
      check("next_strobe_swap", 64'(bus.coeffs), 64'h0008_0007_0006_0005);

      // Reset in the middle of a load.
      cyc(1, 16'd1, 0, 0, 0);
      cyc(1, 16'd2, 0, 0, 0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("midload_rst_coeffs", 64'(bus.coeffs), 64'h0);
      check("midload_rst_ready", 64'(bus.cfg_ready), 64'h1);
      load4(16'd9, 16'd10, 16'd11, 16'd12);
      cyc(0, '0, 0, 1, 0);
      cyc(0, '0, 0, 0, 1);
      check("post_rst_coeffs", 64'(bus.coeffs), 64'h000C_000B_000A_0009);

`ifdef FIR_COEFF_CHK_EN
      load4(16'd1, 16'd2, 16'd4, 16'd8);
      check("chk_good_loaded", 64'(bus.loaded), 64'h1);
      cyc(0, '0, 0, 1, 0);
      cyc(0, '0, 0, 0, 1);
      check("chk_good_coeffs", 64'(bus.coeffs), 64'h0008_0004_0002_0001);
      cyc(1, 16'd1, 0, 0, 0);
      cyc(1, 16'd2, 0, 0, 0);
      cyc(1, 16'd4, 0, 0, 0);
      chk_bad = 1'b1;
      cyc(1, 16'd8, 1, 0, 0);
      chk_bad = 1'b0;
      check("chk_bad_err", 64'(bus.cfg_err), 64'h1);
      check("chk_bad_loaded", 64'(bus.loaded), 64'h0);
      check("chk_bad_coeffs", 64'(bus.coeffs), 64'h0008_0004_0002_0001);
`endif

      // Random traffic, checked every cycle against the model.
      for (int k = 0; k < 3000; k++) begin
         logic v, l;
         int n;
         n = words.size();
         v = ($urandom_range(0, 9) < 6);
         l = (n == TAPS - 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
`ifdef FIR_COEFF_CHK_EN
         chk_bad = ($urandom_range(0, 9) == 0);
`endif
         rst = ($urandom_range(0, 199) == 0);
         cyc(v, WIDTH'($urandom), l, $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
      end
      rst = 1'b0;
      idle(4);
      checking = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
